// File: rtl/unidade_busca.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous instruction memory and hands
// each fetched word to decode over a valid/ready handshake, with branch redirect and halt/resume.
module unidade_busca #(
  parameter int                     ADDR_WIDTH  = 8,
  parameter int                     INSTR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(8'h00),
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = INSTR_WIDTH'(8'hFF),
  parameter int                     MEM_LATENCY = 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  output logic [ADDR_WIDTH-1:0]  Endereco,
  output logic                   LeituraMem,
  input  logic [INSTR_WIDTH-1:0] InstrucaoMem,
  output logic [INSTR_WIDTH-1:0] Instrucao,
  output logic [ADDR_WIDTH-1:0]  PC_Instrucao,
  output logic                   Valido,
  input  logic                   Pronto,
  input  logic                   Desvio,
  input  logic [ADDR_WIDTH-1:0]  DestinoDesvio,
  input  logic                   Continuar,
  output logic                   Parado
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {INICIO, REQ, ESPERA, EMITE, PARADO} estado_t;

  estado_t                estado, estado_n;
  logic [ADDR_WIDTH-1:0]  pc, pc_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [INSTR_WIDTH-1:0] instr_n;
  logic [ADDR_WIDTH-1:0]  pc_instr_n;
  logic                   valido_n;

  // The PC register doubles as the memory address; it only moves when a new fetch is issued.
  assign Endereco = pc;

  // NOTE: every signal gets its hold value before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    estado_n   = estado;
    pc_n       = pc;
    cnt_n      = cnt;
    instr_n    = Instrucao;
    pc_instr_n = PC_Instrucao;
    valido_n   = Valido;

    case (estado)
      INICIO: estado_n = REQ;
      REQ: begin
        estado_n = ESPERA;
        cnt_n    = CNT_W'(MEM_LATENCY - 1);
      end
      ESPERA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          instr_n    = InstrucaoMem;
          pc_instr_n = pc;
          valido_n   = 1'b1;
          estado_n   = EMITE;
        end
      end
      EMITE: begin
        if (Pronto) begin
          pc_n     = pc + 1'b1;
          valido_n = 1'b0;
          estado_n = (Instrucao == HALT_OPCODE) ? PARADO : REQ;
        end
      end
      PARADO:  if (Continuar) estado_n = REQ;
      default: estado_n = INICIO;
    endcase

    // A redirect overrides everything above: any word arriving this cycle is dropped, and an
    // accepted word (including HALT) still counts but the next fetch goes to the target.
    if (Desvio && estado != INICIO) begin
      pc_n       = DestinoDesvio;
      valido_n   = 1'b0;
      instr_n    = Instrucao;
      pc_instr_n = PC_Instrucao;
      estado_n   = REQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado       <= INICIO;
      pc           <= RESET_PC;
      cnt          <= '0;
      Instrucao    <= '0;
      PC_Instrucao <= '0;
      Valido       <= 1'b0;
      LeituraMem   <= 1'b0;
      Parado       <= 1'b0;
    end else begin
      estado       <= estado_n;
      pc           <= pc_n;
      cnt          <= cnt_n;
      Instrucao    <= instr_n;
      PC_Instrucao <= pc_instr_n;
      Valido       <= valido_n;
      LeituraMem   <= (estado_n == REQ);
      Parado       <= (estado_n == PARADO);
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: a scoreboard of expected (PC, word) transfers checked at each
// Valido&Pronto handshake, plus per-scenario timing checks; a second instance uses MEM_LATENCY=3.
module tb_unidade_busca;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
  } xfer_t;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Endereco, InstrucaoMem, Instrucao, PC_Instrucao, DestinoDesvio;
  logic       LeituraMem, Valido, Pronto, Desvio, Continuar, Parado;

  logic       Reset2_n = 1'b0;
  logic [7:0] Endereco2, InstrucaoMem2, Instrucao2, PC_Instrucao2;
  logic       LeituraMem2, Valido2, Parado2;

  logic [7:0] mem [256];
  logic [7:0] mem_q, m2_s0, m2_s1, m2_s2;

  xfer_t sb [$];
  xfer_t exp_m;
  int    vectors = 0;
  int    miscompares = 0;
  logic  found;

  unidade_busca dut (
    .Clock(Clock), .Reset_n(Reset_n), .Endereco(Endereco), .LeituraMem(LeituraMem),
    .InstrucaoMem(InstrucaoMem), .Instrucao(Instrucao), .PC_Instrucao(PC_Instrucao),
    .Valido(Valido), .Pronto(Pronto), .Desvio(Desvio), .DestinoDesvio(DestinoDesvio),
    .Continuar(Continuar), .Parado(Parado)
  );

  unidade_busca #(.MEM_LATENCY(3)) dut3 (
    .Clock(Clock), .Reset_n(Reset2_n), .Endereco(Endereco2), .LeituraMem(LeituraMem2),
    .InstrucaoMem(InstrucaoMem2), .Instrucao(Instrucao2), .PC_Instrucao(PC_Instrucao2),
    .Valido(Valido2), .Pronto(1'b0), .Desvio(1'b0), .DestinoDesvio(8'h00),
    .Continuar(1'b0), .Parado(Parado2)
  );

  always #5 Clock = ~Clock;

  // Synchronous memories: latency 1 for dut, a 3-stage pipeline for dut3.
  always @(posedge Clock) begin
    if (LeituraMem) mem_q <= mem[Endereco];
    if (LeituraMem2) m2_s0 <= mem[Endereco2];
    m2_s1 <= m2_s0;
    m2_s2 <= m2_s1;
  end
  assign InstrucaoMem  = mem_q;
  assign InstrucaoMem2 = m2_s2;

  // Handshake monitor: samples 1 time unit before each rising edge.
  always @(negedge Clock) begin
    #4;
    if (Reset_n === 1'b1 && Valido === 1'b1 && Pronto === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL transfer_unexpected: got pc=%h ins=%h, expected no transfer",
                 PC_Instrucao, Instrucao);
      end else begin
        exp_m = sb.pop_front();
        if ({PC_Instrucao, Instrucao} !== exp_m) begin
          miscompares++;
          $display("FAIL transfer: got pc=%h ins=%h, expected pc=%h ins=%h",
                   PC_Instrucao, Instrucao, exp_m.pc, exp_m.instr);
        end
      end
    end
    if (Reset_n === 1'b1) begin
      vectors++;
      if (LeituraMem === 1'b1 && (Valido !== 1'b0 || Parado !== 1'b0)) begin
        miscompares++;
        $display("FAIL read_strobe: got rd=1 with v=%b parado=%b, expected rd=0",
                 Valido, Parado);
      end
    end
  end

  task automatic do_reset(input logic pronto_v);
    Reset_n = 1'b0;
    Desvio = 1'b0;
    Continuar = 1'b0;
    DestinoDesvio = 8'h00;
    Pronto = pronto_v;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Desvio = 1'b0;
    Continuar = 1'b0;
    DestinoDesvio = 8'h00;
    Pronto = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    mem[8'h40] = 8'h5A;
    repeat (2) @(negedge Clock);
    vectors++;
    if ({Endereco, LeituraMem, Valido, Parado} !== {8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got addr=%h rd=%b v=%b parado=%b, expected 00 0 0 0",
               Endereco, LeituraMem, Valido, Parado);
    end
    vectors++;
    if ({Instrucao, PC_Instrucao} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_ir: got ins=%h pc=%h, expected 00 00", Instrucao, PC_Instrucao);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [7:0] exp_addr;
    sb.push_back({8'h00, 8'h01});
    sb.push_back({8'h01, 8'h02});
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clock);
      vectors++;
      if ({Valido, LeituraMem} !== {1'(k % 3 == 0), 1'(k % 3 == 1)}) begin
        miscompares++;
        $display("FAIL stream_timing edge %0d: got v=%b rd=%b, expected v=%b rd=%b",
                 k, Valido, LeituraMem, (k % 3 == 0), (k % 3 == 1));
      end
      if (k % 3 == 1) begin
        exp_addr = 8'((k - 1) / 3);
        vectors++;
        if (Endereco !== exp_addr) begin
          miscompares++;
          $display("FAIL stream_addr edge %0d: got %h, expected %h", k, Endereco, exp_addr);
        end
      end
    end
    Pronto = 1'b0;
    vectors++;
    if ({Valido, PC_Instrucao, Instrucao} !== {1'b1, 8'h02, 8'h03}) begin
      miscompares++;
      $display("FAIL stream_third: got v=%b pc=%h ins=%h, expected 1 02 03",
               Valido, PC_Instrucao, Instrucao);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      vectors++;
      if ({Valido, LeituraMem, PC_Instrucao, Instrucao} !== {2'b10, 8'h02, 8'h03}) begin
        miscompares++;
        $display("FAIL stall_hold cycle %0d: got v=%b rd=%b pc=%h ins=%h, expected 1 0 02 03",
                 i, Valido, LeituraMem, PC_Instrucao, Instrucao);
      end
    end
    sb.push_back({8'h02, 8'h03});
    Pronto = 1'b1;
    @(negedge Clock);
    vectors++;
    if ({Valido, LeituraMem, Endereco} !== {2'b01, 8'h03}) begin
      miscompares++;
      $display("FAIL stall_advance: got v=%b rd=%b addr=%h, expected 0 1 03",
               Valido, LeituraMem, Endereco);
    end
  endtask

  task automatic test_desvio_espera();
    @(negedge Clock);
    vectors++;
    if ({Valido, LeituraMem, Endereco} !== {2'b00, 8'h03}) begin
      miscompares++;
      $display("FAIL desvio_wait: got v=%b rd=%b addr=%h, expected 0 0 03",
               Valido, LeituraMem, Endereco);
    end
    Desvio = 1'b1;
    DestinoDesvio = 8'h40;
    @(negedge Clock);
    Desvio = 1'b0;
    vectors++;
    if ({Valido, LeituraMem, Endereco} !== {2'b01, 8'h40}) begin
      miscompares++;
      $display("FAIL desvio_req: got v=%b rd=%b addr=%h, expected 0 1 40",
               Valido, LeituraMem, Endereco);
    end
    sb.push_back({8'h40, 8'h5A});
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL desvio_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    mem[8'h80] = 8'h99;
    sb.push_back({8'h00, 8'h01});
    sb.push_back({8'h80, 8'h99});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge Clock);
      found = (Valido === 1'b1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL b2b_valid: got v=%b after 10 cycles, expected 1", Valido);
    end
    Desvio = 1'b1;
    DestinoDesvio = 8'h80;
    @(negedge Clock);
    Desvio = 1'b0;
    vectors++;
    if ({Valido, LeituraMem, Endereco} !== {2'b01, 8'h80}) begin
      miscompares++;
      $display("FAIL b2b_target: got v=%b rd=%b addr=%h, expected 0 1 80",
               Valido, LeituraMem, Endereco);
    end
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    mem[8'h05] = 8'hFF;
    for (int i = 0; i < 5; i++) sb.push_back({8'(i), 8'(i + 1)});
    sb.push_back({8'h05, 8'hFF});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clock);
      found = (Parado === 1'b1);
    end
    vectors++;
    if (!found || sb.size() != 0) begin
      miscompares++;
      $display("FAIL halt_enter: got parado=%b pending=%0d, expected 1 0", Parado, sb.size());
      sb.delete();
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      vectors++;
      if ({Parado, Valido, LeituraMem} !== 3'b100) begin
        miscompares++;
        $display("FAIL halt_hold cycle %0d: got parado=%b v=%b rd=%b, expected 1 0 0",
                 i, Parado, Valido, LeituraMem);
      end
    end
    Continuar = 1'b1;
    sb.push_back({8'h06, 8'h07});
    @(negedge Clock);
    Continuar = 1'b0;
    vectors++;
    if ({Parado, LeituraMem, Endereco} !== {2'b01, 8'h06}) begin
      miscompares++;
      $display("FAIL halt_resume: got parado=%b rd=%b addr=%h, expected 0 1 06",
               Parado, LeituraMem, Endereco);
    end
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL halt_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    mem[8'hFF] = 8'h3C;
    @(negedge Clock);
    Desvio = 1'b1;
    DestinoDesvio = 8'hFF;
    @(negedge Clock);
    Desvio = 1'b0;
    vectors++;
    if ({LeituraMem, Endereco} !== {1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL wrap_req: got rd=%b addr=%h, expected 1 ff", LeituraMem, Endereco);
    end
    sb.push_back({8'hFF, 8'h3C});
    sb.push_back({8'h00, 8'h01});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge Clock);
      found = (Valido === 1'b1);
    end
    @(negedge Clock);
    vectors++;
    if ({found, LeituraMem, Endereco} !== {2'b11, 8'h00}) begin
      miscompares++;
      $display("FAIL wrap_addr: got seen=%b rd=%b addr=%h, expected 1 1 00",
               found, LeituraMem, Endereco);
    end
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_espera();
    do_reset(1'b1);
    @(negedge Clock);
    Desvio = 1'b1;
    DestinoDesvio = 8'h20;
    @(negedge Clock);
    Desvio = 1'b0;
    @(negedge Clock);
    vectors++;
    if ({LeituraMem, Valido, Endereco} !== {2'b00, 8'h20}) begin
      miscompares++;
      $display("FAIL rst_wait: got rd=%b v=%b addr=%h, expected 0 0 20",
               LeituraMem, Valido, Endereco);
    end
    #2 Reset_n = 1'b0;
    #1;
    vectors++;
    if ({LeituraMem, Valido, Endereco} !== {2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_async: got rd=%b v=%b addr=%h, expected 0 0 00",
               LeituraMem, Valido, Endereco);
    end
    @(negedge Clock);
    vectors++;
    if ({Valido, Instrucao} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL rst_nocapture: got v=%b ins=%h, expected 0 00", Valido, Instrucao);
    end
    Reset_n = 1'b1;
    sb.push_back({8'h00, 8'h01});
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clock);
      vectors++;
      if (Valido !== 1'(k == 3)) begin
        miscompares++;
        $display("FAIL rst_refetch edge %0d: got v=%b, expected %b", k, Valido, (k == 3));
      end
    end
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    Reset_n = 1'b0;
  endtask

  task automatic test_latencia3();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    @(negedge Clock);
    Reset2_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      vectors++;
      if ({Valido2, LeituraMem2} !== {1'(k >= 5), 1'(k == 1)}) begin
        miscompares++;
        $display("FAIL lat3_timing edge %0d: got v=%b rd=%b, expected v=%b rd=%b",
                 k, Valido2, LeituraMem2, (k >= 5), (k == 1));
      end
      if (k == 5) begin
        vectors++;
        if ({PC_Instrucao2, Instrucao2} !== {8'h00, 8'h01}) begin
          miscompares++;
          $display("FAIL lat3_word: got pc=%h ins=%h, expected 00 01", PC_Instrucao2, Instrucao2);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_desvio_espera();
    test_back_to_back();
    test_halt();
    test_wrap();
    test_reset_espera();
    test_latencia3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
